// File: rtl/video_pkg.sv
// Shared video types and defaults for the colour-modifier path.
package video_pkg;

  localparam int CH_W  = 10;
  localparam int MOD_W = 6;

  // One pixel at default width, R in the MSBs.
  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

  // One modifier set as latched at start of frame.
  typedef struct packed {
    logic [MOD_W-1:0] r;
    logic [MOD_W-1:0] g;
    logic [MOD_W-1:0] b;
    logic             div;
  } mod_set_t;

  // Multiply-by-one on every channel leaves the pixel untouched.
  localparam mod_set_t MOD_PASSTHRU = '{r: MOD_W'(1), g: MOD_W'(1), b: MOD_W'(1), div: 1'b0};

endpackage

// File: rtl/chan_scale.sv
// Single-channel modifier: saturating multiply, or right shift by floor(log2(m)).
// Purely combinational; a zero modifier in divide mode passes the channel through.
module chan_scale #(
  parameter int CH_W  = 10,
  parameter int MOD_W = 6
) (
  input  logic [CH_W-1:0]  i_chan,
  input  logic [MOD_W-1:0] i_mod,
  input  logic             i_div,
  output logic [CH_W-1:0]  o_chan
);

  localparam int SH_W = (MOD_W > 1) ? $clog2(MOD_W) : 1;

  logic [CH_W+MOD_W-1:0] w_prod;
  logic [SH_W-1:0]       w_shift;

  assign w_prod = {{MOD_W{1'b0}}, i_chan} * {{CH_W{1'b0}}, i_mod};

  // Position of the highest set modifier bit, i.e. floor(log2(m)).
  always_comb begin
    w_shift = '0;
    for (int i = 0; i < MOD_W; i++) begin
      if (i_mod[i]) w_shift = SH_W'(i);
    end
  end

  // Select between saturated product and shifted channel.
  always_comb begin
    o_chan = i_chan;
    if (!i_div) begin
      o_chan = (|w_prod[CH_W+MOD_W-1:CH_W]) ? {CH_W{1'b1}} : w_prod[CH_W-1:0];
    end else if (i_mod != '0) begin
      o_chan = i_chan >> w_shift;
    end
  end

endmodule

// File: rtl/pixel_mod_apply.sv
// Applies per-channel colour modifiers to an RGB stream through a two-stage
// pipeline. The modifier set is latched on each accepted sop beat so a filter
// change mid-frame takes effect only from the next frame.
//
// Handshake: a beat transfers on a clock edge where valid & ready are both 1.
// Both stages advance together when en = !out_valid | out_ready, and
// in_ready = en, so in_ready never depends on in_valid. While out_valid is
// held without out_ready, outputs, stage contents and the shadow set freeze.
module pixel_mod_apply #(
  parameter int CH_W  = video_pkg::CH_W,
  parameter int MOD_W = video_pkg::MOD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MOD_W-1:0]  r_mod,
  input  logic [MOD_W-1:0]  g_mod,
  input  logic [MOD_W-1:0]  b_mod,
  input  logic              div_flag,
  input  logic [3*CH_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic              in_ready,
  output logic [3*CH_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_sop,
  output logic              out_eop,
  input  logic              out_ready
);

  import video_pkg::*;

  typedef struct packed {
    logic [MOD_W-1:0] r;
    logic [MOD_W-1:0] g;
    logic [MOD_W-1:0] b;
    logic             div;
  } mod_t;

  localparam mod_t PASSTHRU = '{r:   MOD_W'(MOD_PASSTHRU.r),
                                g:   MOD_W'(MOD_PASSTHRU.g),
                                b:   MOD_W'(MOD_PASSTHRU.b),
                                div: MOD_PASSTHRU.div};

  // Shadow modifier set, valid for the remainder of the current frame.
  mod_t r_shadow;

  // Stage 1: pixel plus the modifier set it will use.
  logic              r_s1_valid;
  logic              r_s1_sop;
  logic              r_s1_eop;
  logic [3*CH_W-1:0] r_s1_data;
  mod_t              r_s1_mod;

  // Stage 2: arithmetic result, drives the outputs directly.
  logic              r_s2_valid;
  logic              r_s2_sop;
  logic              r_s2_eop;
  logic [3*CH_W-1:0] r_s2_data;

  logic              w_en;
  logic              w_accept;
  mod_t              w_live;
  mod_t              w_sel;
  logic [3*CH_W-1:0] w_res;

  assign w_en     = !r_s2_valid | out_ready;
  assign w_accept = in_valid & w_en;
  assign w_live   = '{r: r_mod, g: g_mod, b: b_mod, div: div_flag};
  // An sop beat uses the set it is capturing, not the stale shadow.
  assign w_sel    = in_sop ? w_live : r_shadow;

  assign in_ready  = w_en;
  assign out_valid = r_s2_valid;
  assign out_sop   = r_s2_sop;
  assign out_eop   = r_s2_eop;
  assign out_data  = r_s2_data;

  // Reload the shadow set from the live ports on every accepted sop beat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shadow <= PASSTHRU;
    end else if (w_accept && in_sop) begin
      r_shadow <= w_live;
    end
  end

  // Stage 1 register: capture beat, framing flags and selected modifiers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sop   <= 1'b0;
      r_s1_eop   <= 1'b0;
      r_s1_data  <= '0;
      r_s1_mod   <= PASSTHRU;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      r_s1_sop   <= in_valid & in_sop;
      r_s1_eop   <= in_valid & in_eop;
      r_s1_data  <= in_data;
      r_s1_mod   <= w_sel;
    end
  end

  chan_scale #(.CH_W(CH_W), .MOD_W(MOD_W)) u_scale_r (
    .i_chan (r_s1_data[3*CH_W-1:2*CH_W]),
    .i_mod  (r_s1_mod.r),
    .i_div  (r_s1_mod.div),
    .o_chan (w_res[3*CH_W-1:2*CH_W])
  );

  chan_scale #(.CH_W(CH_W), .MOD_W(MOD_W)) u_scale_g (
    .i_chan (r_s1_data[2*CH_W-1:CH_W]),
    .i_mod  (r_s1_mod.g),
    .i_div  (r_s1_mod.div),
    .o_chan (w_res[2*CH_W-1:CH_W])
  );

  chan_scale #(.CH_W(CH_W), .MOD_W(MOD_W)) u_scale_b (
    .i_chan (r_s1_data[CH_W-1:0]),
    .i_mod  (r_s1_mod.b),
    .i_div  (r_s1_mod.div),
    .o_chan (w_res[CH_W-1:0])
  );

  // Stage 2 register: capture the modified pixel and forward framing flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_sop   <= 1'b0;
      r_s2_eop   <= 1'b0;
      r_s2_data  <= '0;
    end else if (w_en) begin
      r_s2_valid <= r_s1_valid;
      r_s2_sop   <= r_s1_sop;
      r_s2_eop   <= r_s1_eop;
      r_s2_data  <= w_res;
    end
  end

endmodule

// File: tb/tb_pixel_mod_apply.sv
// Directed bench for pixel_mod_apply: reset, passthrough latency, multiply,
// divide, frame-latched modifiers, backpressure and mid-frame reset.
module tb_pixel_mod_apply;

  localparam int CH_W  = 10;
  localparam int MOD_W = 6;
  localparam int W     = 3*CH_W + 2;

  logic              clk;
  logic              rst_n;
  logic [MOD_W-1:0]  r_mod, g_mod, b_mod;
  logic              div_flag;
  logic [3*CH_W-1:0] in_data;
  logic              in_valid, in_sop, in_eop, in_ready;
  logic [3*CH_W-1:0] out_data;
  logic              out_valid, out_sop, out_eop, out_ready;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] got_q[$];
  logic [W-1:0] exp_q[$];

  pixel_mod_apply #(.CH_W(CH_W), .MOD_W(MOD_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .r_mod     (r_mod),
    .g_mod     (g_mod),
    .b_mod     (b_mod),
    .div_flag  (div_flag),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_ready (out_ready)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor: record every completed output transfer.
  always @(negedge clk) begin
    if (out_valid && out_ready) got_q.push_back({out_sop, out_eop, out_data});
  end

  function automatic logic [3*CH_W-1:0] pix(int r, int g, int b);
    return {CH_W'(r), CH_W'(g), CH_W'(b)};
  endfunction

  function automatic logic [W-1:0] beat(logic s, logic e, logic [3*CH_W-1:0] d);
    return {s, e, d};
  endfunction

  // Driver: present one beat and hold it until accepted (bounded).
  task automatic send(logic [3*CH_W-1:0] d, logic s, logic e);
    logic acc;
    int   guard;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    in_valid = 1'b1;
    acc      = 1'b0;
    guard    = 0;
    while (!acc && guard < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    n_cmp++;
    if (!acc) begin
      n_err++;
      $display("FAIL send_accept: beat %h not accepted within %0d cycles", d, guard);
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic set_mods(int r, int g, int b, logic d);
    r_mod    = MOD_W'(r);
    g_mod    = MOD_W'(g);
    b_mod    = MOD_W'(b);
    div_flag = d;
  endtask

  task automatic wait_outputs(int n);
    for (int c = 0; c < 60 && got_q.size() < n; c++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_sop !== 1'b0) begin n_err++; $display("FAIL reset_out_sop: got %b want 0", out_sop); end
    n_cmp++; if (out_eop !== 1'b0) begin n_err++; $display("FAIL reset_out_eop: got %b want 0", out_eop); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // No sop since reset: passthrough shadow set applies; check 2-cycle latency.
  task automatic test_passthru_latency();
    set_mods(0, 0, 0, 1'b0);
    send(pix(100, 200, 300), 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL latency_early: out_valid got %b want 0 one cycle after accept", out_valid); end
    @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL latency_valid: out_valid got %b want 1", out_valid); end
    n_cmp++; if (out_data !== pix(100, 200, 300)) begin n_err++; $display("FAIL passthru_data: got %h want %h", out_data, pix(100, 200, 300)); end
    drain();
  endtask

  task automatic test_multiply();
    set_mods(2, 2, 2, 1'b0);
    exp_q.push_back(beat(1'b1, 1'b1, pix(200, 1023, 1023)));
    send(pix(100, 600, 1023), 1'b1, 1'b1);
    wait_outputs(1);
    n_cmp++;
    if (got_q.size() != 1) begin
      n_err++; $display("FAIL mul_count: got %0d beats want 1", got_q.size());
    end else if (got_q[0] !== exp_q[0]) begin
      n_err++; $display("FAIL mul_sat: got %h want %h", got_q[0], exp_q[0]);
    end
    drain();
  endtask

  task automatic test_divide();
    set_mods(4, 6, 0, 1'b1);
    exp_q.push_back(beat(1'b1, 1'b1, pix(100, 100, 400)));
    send(pix(400, 400, 400), 1'b1, 1'b1);
    wait_outputs(1);
    n_cmp++;
    if (got_q.size() != 1) begin
      n_err++; $display("FAIL div_count: got %0d beats want 1", got_q.size());
    end else if (got_q[0] !== exp_q[0]) begin
      n_err++; $display("FAIL div_shift: got %h want %h", got_q[0], exp_q[0]);
    end
    drain();
  endtask

  // Live modifiers change on pixel 3; the frame keeps its latched set.
  task automatic test_midframe_change();
    set_mods(1, 1, 1, 1'b0);
    send(pix(10, 20, 30), 1'b1, 1'b0);
    send(pix(40, 50, 60), 1'b0, 1'b0);
    set_mods(0, 0, 0, 1'b0);
    send(pix(70, 80, 90), 1'b0, 1'b0);
    send(pix(1023, 512, 7), 1'b0, 1'b0);
    send(pix(11, 22, 33), 1'b0, 1'b1);
    send(pix(5, 6, 7), 1'b1, 1'b1);
    exp_q.push_back(beat(1'b1, 1'b0, pix(10, 20, 30)));
    exp_q.push_back(beat(1'b0, 1'b0, pix(40, 50, 60)));
    exp_q.push_back(beat(1'b0, 1'b0, pix(70, 80, 90)));
    exp_q.push_back(beat(1'b0, 1'b0, pix(1023, 512, 7)));
    exp_q.push_back(beat(1'b0, 1'b1, pix(11, 22, 33)));
    exp_q.push_back(beat(1'b1, 1'b1, pix(0, 0, 0)));
    wait_outputs(6);
    n_cmp++;
    if (got_q.size() != 6) begin n_err++; $display("FAIL midframe_count: got %0d beats want 6", got_q.size()); end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL midframe_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    drain();
  endtask

  // out_ready cycles 1,0,0,1 under continuous input.
  task automatic test_backpressure();
    logic              pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [3*CH_W-1:0] held;
    logic              held_v;
    set_mods(3, 3, 3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(beat(i == 0, i == 5, pix(3*(i*10+1), 3*(i*10+2), 3*(i*10+3))));
    end
    held   = '0;
    held_v = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(pix(i*10+1, i*10+2, i*10+3), i == 0, i == 5);
      end
      begin
        for (int c = 0; c < 24; c++) begin
          out_ready = pat[c % 4];
          @(negedge clk);
          if (!out_ready && out_valid) begin
            n_cmp++;
            if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
            if (held_v) begin
              n_cmp++;
              if (out_data !== held) begin n_err++; $display("FAIL stall_stable: got %h want %h", out_data, held); end
            end
            held   = out_data;
            held_v = 1'b1;
          end else begin
            held_v = 1'b0;
          end
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_outputs(6);
    n_cmp++;
    if (got_q.size() != 6) begin n_err++; $display("FAIL bp_count: got %0d beats want 6", got_q.size()); end
    for (int i = 0; i < 6 && i < got_q.size(); i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_err++; $display("FAIL bp_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    drain();
  endtask

  // Two beats stalled in the pipe, then reset: neither may come out.
  task automatic test_reset_midframe();
    out_ready = 1'b0;
    set_mods(2, 2, 2, 1'b0);
    send(pix(1, 2, 3), 1'b1, 1'b0);
    send(pix(4, 5, 6), 1'b0, 1'b0);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rstmid_inflight: out_valid got %b want 1", out_valid); end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_mods(3, 3, 3, 1'b0);
    exp_q.push_back(beat(1'b1, 1'b1, pix(30, 60, 90)));
    send(pix(10, 20, 30), 1'b1, 1'b1);
    wait_outputs(1);
    repeat (4) @(posedge clk);
    #1;
    n_cmp++;
    if (got_q.size() != 1) begin
      n_err++; $display("FAIL rstmid_count: got %0d beats want 1", got_q.size());
    end else if (got_q[0] !== exp_q[0]) begin
      n_err++; $display("FAIL rstmid_beat: got %h want %h", got_q[0], exp_q[0]);
    end
    drain();
  endtask

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_sop    = 1'b0;
    in_eop    = 1'b0;
    out_ready = 1'b1;
    set_mods(1, 1, 1, 1'b0);
    test_reset();
    test_passthru_latency();
    test_multiply();
    test_divide();
    test_midframe_change();
    test_backpressure();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
